// File: rtl/dcache_mem_pkg.sv
// rtl/dcache_mem_pkg.sv - shared types and constants for the D-cache memory responder
package dcache_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int BLOCK_W     = 128;
    localparam int DEF_LATENCY = 4;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/mem_lat_lfsr.sv
// rtl/mem_lat_lfsr.sv - 8-bit maximal-length LFSR that steps once per enable
module mem_lat_lfsr
    import dcache_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// rtl/dcache_mem_responder.sv - block memory responder; DCACHE_MEM_RAND_LAT_EN adds LFSR latency jitter
module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               proc_reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [BLOCK_W-1:0] mem_wdata,
    output logic [BLOCK_W-1:0] mem_rdata,
    output logic               mem_ready
);

`ifdef DCACHE_MEM_RAND_LAT_EN
    localparam int CNT_W = 9;
`else
    localparam int CNT_W = 8;
`endif

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [BLOCK_W-1:0]    wdata_q, wdata_d;
    logic [BLOCK_W-1:0]    rdata_q, rdata_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  we;
    logic [DEPTH_LOG2-1:0] widx;
    logic [BLOCK_W-1:0]    wval;
    logic [CNT_W-1:0]      lat_sel;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  unused_addr_hi;

    logic [BLOCK_W-1:0] mem [2**DEPTH_LOG2];

    assign req_idx        = mem_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

`ifdef DCACHE_MEM_RAND_LAT_EN
    logic [7:0] lfsr_val;
    logic       unused_lfsr_hi;

    mem_lat_lfsr u_lfsr (
        .clk  (clk),
        .rst  (proc_reset),
        .adv  (accept),
        .lfsr (lfsr_val)
    );

    assign lat_sel        = CNT_W'(LATENCY) + CNT_W'(lfsr_val[2:0]);
    assign unused_lfsr_hi = ^lfsr_val[7:3];
`else
    assign lat_sel = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        accept  = 1'b0;
        we      = 1'b0;
        widx    = addr_q;
        wval    = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    accept  = 1'b1;
                    op_wr_d = mem_write;
                    addr_d  = req_idx;
                    wdata_d = mem_wdata;
                    // A one-cycle latency completes straight from the live request.
                    if (lat_sel == CNT_W'(1)) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        if (mem_write) begin
                            we   = 1'b1;
                            widx = req_idx;
                            wval = mem_wdata;
                        end else begin
                            rdata_d = mem[req_idx];
                        end
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = lat_sel - CNT_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    if (op_wr_q) begin
                        we = 1'b1;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Reset on the commit edge drops an in-flight write.
    always_ff @(posedge clk) begin
        if (we && !proc_reset) begin
            mem[widx] <= wval;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb/tb_dcache_mem_responder.sv - randomized self-checking bench for dcache_mem_responder
module tb_dcache_mem_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [127:0] model_mem [int];
    logic [127:0] model_rdata;
    logic [7:0]   model_lfsr;
    int           written [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dcache_mem_responder dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_lat(output int l);
`ifdef DCACHE_MEM_RAND_LAT_EN
        l = LAT + int'(model_lfsr[2:0]);
        model_lfsr = {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
`else
        l = LAT;
`endif
    endtask

    // Called at a negedge; returns at the negedge where mem_ready is seen, request still held.
    task automatic txn(input bit wr, input logic [27:0] a, input logic [127:0] d,
                       input bit mutate, output int ready_cyc, output int exp_lat);
        int n;
        int idx;
        idx = int'(a[9:0]);
        next_lat(exp_lat);
        mem_write = wr;
        mem_read  = !wr;
        mem_addr  = a;
        mem_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mutate && n == 1) begin
                mem_addr  = 28'h9;
                mem_write = 1'b0;
                mem_wdata = ~d;
            end
        end while (!mem_ready && n < 300);
        ready_cyc = cyc;
        chk("latency", 128'(n), 128'(exp_lat));
`ifdef DCACHE_MEM_RAND_LAT_EN
        chk("lat_range", 128'(n >= 4 && n <= 11), 128'(1));
`endif
        if (wr) begin
            chk("wr_rdata_hold", mem_rdata, model_rdata);
            model_mem[idx] = d;
            if (!(idx inside {written})) written.push_back(idx);
        end else if (model_mem.exists(idx)) begin
            model_rdata = model_mem[idx];
            chk("rd_data", mem_rdata, model_rdata);
        end
    endtask

    task automatic finish_txn();
        @(negedge clk);
        chk("pulse_1cyc", 128'(mem_ready), 128'(0));
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int c1, c2, l1, l2, dl;
        logic [127:0] d;
        logic [27:0]  a;

        proc_reset  = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        model_lfsr  = 8'hA5;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ready", 128'(mem_ready), 128'(0));
            chk("idle_rdata", mem_rdata, 128'(0));
        end

        // write then read back
        txn(1'b1, 28'h5, 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111, 1'b0, c1, l1);
        finish_txn();
        txn(1'b0, 28'h5, '0, 1'b0, c1, l1);
        finish_txn();

        // write-back then refill, issued right after RESP
        txn(1'b1, 28'h23, {4{$urandom}}, 1'b0, c1, l1);
        finish_txn();
        txn(1'b1, 28'h13, {4{$urandom}}, 1'b0, c1, l1);
        @(negedge clk);
        chk("pulse_1cyc", 128'(mem_ready), 128'(0));
        txn(1'b0, 28'h23, '0, 1'b0, c2, l2);
        chk("b2b_spacing", 128'(c2 - c1), 128'(1 + l2));
        finish_txn();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_double_accept", 128'(mem_ready), 128'(0));
        end

        // address/data/request changes after acceptance are ignored
        d = {4{$urandom}};
        txn(1'b1, 28'h9, d, 1'b0, c1, l1);
        finish_txn();
        txn(1'b1, 28'h7, {4{$urandom}}, 1'b1, c1, l1);
        finish_txn();
        txn(1'b0, 28'h9, '0, 1'b0, c1, l1);
        finish_txn();
        txn(1'b0, 28'h7, '0, 1'b0, c1, l1);
        finish_txn();

        // reset while a write to addr 3 is in flight
        txn(1'b1, 28'h3, {4{$urandom}}, 1'b0, c1, l1);
        finish_txn();
        next_lat(dl);
        mem_write = 1'b1;
        mem_addr  = 28'h3;
        mem_wdata = {4{$urandom}};
        @(negedge clk);
        @(negedge clk);
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(mem_ready), 128'(0));
        chk("rst_rdata", mem_rdata, 128'(0));
        proc_reset  = 1'b0;
        model_lfsr  = 8'hA5;
        model_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_quiet", 128'(mem_ready), 128'(0));
        end
        txn(1'b0, 28'h3, '0, 1'b0, c1, l1);
        finish_txn();

        // random mix with aliasing upper address bits and random gaps
        for (int t = 0; t < 60; t++) begin
            bit wr;
            int idx;
            wr = (written.size() == 0) || ($urandom_range(0, 2) == 0);
            if (wr) idx = 32 + $urandom_range(0, 15);
            else    idx = written[$urandom_range(0, written.size() - 1)];
            a = {18'($urandom), 10'(idx)};
            txn(wr, a, {4{$urandom}}, 1'b0, c1, l1);
            finish_txn();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data cache's 128-bit block interface: accepts one block read or block write per transaction and answers with a single-cycle mem_ready after a programmable latency.
- Sits between the D-cache's mem_* port and backing storage. It is synthesizable block storage for FPGA bring-up and doubles as the slow-memory model in cache benches.
- Strictly one outstanding transaction at a time; no pipelining.

Parameters:
- ADDR_W, 28, block address width; must match the cache's mem_addr.
- DEPTH_LOG2, 10, log2 of stored blocks; storage is indexed by mem_addr[DEPTH_LOG2-1:0] and upper bits are ignored (aliasing).
- LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- proc_reset  in  1  synchronous, active-high reset.
- mem_read  in  1  block read request; level, held by the initiator until mem_ready.
- mem_write  in  1  block write request; level, held by the initiator until mem_ready.
- mem_addr  in  ADDR_W  block address.
- mem_wdata  in  128  write block data.
- mem_rdata  out  128  read block data; valid only while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (proc_reset). All outputs are registered.
- Reset values: mem_ready=0, mem_rdata=0, state=IDLE, counter=0. Storage contents are not cleared by reset and are undefined until written.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read|mem_write is sampled high, latch op, addr and wdata, load counter=LATENCY-1, and go to BUSY. If LATENCY=1, go directly to RESP.
  - If both mem_read and mem_write are high, write wins.
- BUSY:
  - Decrement counter each cycle. At counter==0, go to RESP.
  - Inputs are ignored. Address or data changes after acceptance have no effect.
  - Request deassertion does not abort: the transaction always completes.
- Entering RESP (registered on the same edge):
  - mem_ready=1.
  - Read: mem_rdata=mem[latched addr].
  - Write: mem[latched addr]<=latched wdata; mem_rdata keeps its prior value.
- RESP: lasts exactly one cycle and returns to IDLE unconditionally. Requests seen during RESP are not accepted. The initiator's request remains visible during this cycle and must not be re-accepted.
- Latency: request first sampled at edge A gives mem_ready high during the cycle after edge A+LATENCY-1, i.e. ready is observed LATENCY cycles after acceptance.
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP. This covers the cache's write-back-then-refill sequence of two transactions with different addresses.
- Read-after-write to the same address returns the written data. The write is committed no later than the RESP edge.
- Reset mid-transaction: return to IDLE, mem_ready=0, and an in-flight write is not committed.
- Width rules: counter is 8 bits. Index truncation is silent.

Optional Feature:
- Macro: DCACHE_MEM_RAND_LAT_EN.
- Defined:
  - An 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances once per accepted request.
  - lfsr[2:0] is added to LATENCY at acceptance, giving a latency of LATENCY..LATENCY+7.
  - Counter width must cover 255+7.
- Undefined: latency is exactly LATENCY and there is no LFSR logic.

Decomposition:
- Shared package dcache_mem_pkg:
  - state enum (IDLE, BUSY, RESP);
  - BLOCK_W=128;
  - default LATENCY constant;
  - LFSR seed and tap constants.
- One sub-module: mem_lat_lfsr, the 8-bit LFSR with advance enable. It is instantiated only under DCACHE_MEM_RAND_LAT_EN.
- Storage is an inferred array inside the top module.

Test Plan:
- Reset/idle: hold proc_reset 2 cycles, then release with no requests. Required: mem_ready=0 and mem_rdata=0 for 20 cycles.
- Write then read, LATENCY=4:
  - Write addr 28'h0000005 with data 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111 held until ready. Required: mem_ready pulses exactly one cycle, 4 cycles after acceptance.
  - Then read addr 5. Required: mem_rdata equals the written value in the ready cycle.
- Back-to-back (write-back plus refill):
  - Write addr 0x13, then read addr 0x23 issued in the cycle after RESP. Required: two ready pulses 5 cycles apart (4 latency + 1 RESP).
  - A request still high during RESP is not double-accepted.
- Mid-transaction changes: change mem_addr from 7 to 9 and drop mem_write after 1 cycle of BUSY. Required: write still completes to addr 7 and addr 9 is unchanged.
- Reset during BUSY of a write to addr 3 (old value X0): assert proc_reset at counter=2. Required: mem_ready stays 0 and a later read of addr 3 returns X0.
- Random latency, macro defined: 50 read transactions. Required: every latency is within 4..11, and the sequence matches the reference LFSR model seeded 8'hA5.
